axil_regfile: RTL and testbench
===============================

# axil_regfile

AXI4-Lite slave register file that sits directly downstream of the `axi_lite_if` bus and terminates it through the `slave` modport. It holds `NUM_REGS` 32-bit read/write registers with byte-strobe writes, and returns OKAY/SLVERR responses. It also drives the full register contents to fabric logic as a flat vector. It is the standard control/status endpoint for blocks hung off an AXI4-Lite master.

## Interface
- `NUM_REGS`, 8: number of 32-bit registers, 1..256.
- `BASE_ADDR`, 32'h0: byte address of register 0, 4-byte aligned.
- `RESET_VAL`, 32'h0: reset value of every register.

- `ACLK`  input  1  bus clock, all logic on rising edge.
- `ARESETn`  input  1  asynchronous active-low reset.
- `s_axi`  interface  `axi_lite_if.slave`  AW/W/B/AR/R channels, 32-bit address/data, 4-bit WSTRB.
- `regs_o`  output  `NUM_REGS*32`  register contents, register i at bits [32*i +: 32], registered.

## Operation
- Decode: the address is in range if `BASE_ADDR <= ADDR < BASE_ADDR + 4*NUM_REGS`. Index = `(ADDR - BASE_ADDR) >> 2`. `ADDR[1:0]` is ignored.
- Write path: AW and W are captured independently into one-entry holding slots, each with a full flag. They may arrive in either order or in the same cycle.
  - `AWREADY = !aw_full`, `WREADY = !w_full`.
  - Commit happens on the edge where `aw_full && w_full && !BVALID`:
    - In range: byte k of the register is updated iff `WSTRB[k]`, `BRESP=2'b00`.
    - Out of range: no register changes, `BRESP=2'b10` (SLVERR).
    - Both full flags clear and `BVALID` sets.
  - `BVALID` holds until `BREADY`. A second AW/W may be captured while B is pending, but it does not commit until B completes.
- Read path: `ARREADY = !RVALID`.
  - On an AR handshake, the next edge loads `RDATA` and sets `RVALID`.
    - In range: `RDATA` = register value, `RRESP=2'b00`.
    - Out of range: `RDATA=0`, `RRESP=2'b10`.
  - `RDATA`/`RRESP`/`RVALID` hold stable until `RREADY`.
- Read and write channels are fully independent. If a read samples the same register on the commit edge of a write, it returns the pre-write value.
- `AWPROT`/`ARPROT` are ignored unless `AXIL_REGFILE_PROT_CHK_EN` is defined.

## Timing
- Reset (async assert, sync release):
  - All registers = `RESET_VAL`.
  - `BVALID=RVALID=0`, `BRESP=RRESP=0`, `RDATA=0`.
  - `AWREADY=WREADY=ARREADY=0` (held by a registered `rdy_en` flag).
  - Ready signals rise on the first `ACLK` edge after `ARESETn` goes high.
- Write latency:
  - AW and W handshake in cycle N → register and `regs_o` update at edge N+1, `BVALID=1` in cycle N+1.
  - Minimum 2 cycles per write with `BREADY` held high.
- Read latency:
  - AR handshake in cycle N → `RVALID=1` in cycle N+1.
  - Back-to-back reads every 2 cycles with `RREADY` held high, since ARREADY is low while RVALID is high.
- Stalled responses: if `BREADY`/`RREADY` stay low indefinitely, the response is held and no further commit or AR accept occurs on that path.
- Reset mid-transaction: captured AW/W/AR and pending B/R are discarded and no response is issued. Register writes not yet committed are lost.

## Configuration
- `AXIL_REGFILE_PROT_CHK_EN` defined:
  - A write whose captured `AWPROT[0]==0` (unprivileged) commits with `BRESP=2'b10` and no register change.
  - A read with `ARPROT[0]==0` returns `RDATA=0`, `RRESP=2'b10`.
  - This check is applied in addition to the range check.
- Not defined: PROT bits are ignored and all in-range accesses get OKAY.

## Test plan
- Reset release: `AWREADY/WREADY/ARREADY` are 0 in reset and 1 one edge later. `regs_o` = all `RESET_VAL`.
- AW first, W three cycles later:
  - Stimulus: write 32'hDEADBEEF with `WSTRB=4'hF` to `BASE_ADDR+8`.
  - Required: `BRESP=0` one cycle after the W handshake, and register 2 = 32'hDEADBEEF.
  - Then write W before AW, data 32'h00000011 with `WSTRB=4'b0001` to the same address → register 2 = 32'hDEADBE11.
- Out of range:
  - Write to `BASE_ADDR+4*NUM_REGS` → `BRESP=2'b10`, `regs_o` unchanged.
  - Read from the same address → `RDATA=0`, `RRESP=2'b10`.
- Backpressure:
  - Hold `BREADY=0` for 5 cycles while issuing a second AW/W. Second AW/W are accepted, but the register is unchanged until the first B handshakes, then the commit lands the next edge.
  - Hold `RREADY=0`: `RDATA` stable and `ARREADY=0` throughout.
- Simultaneous access: read of register 3 on the same edge as a write commit to register 3 → `RDATA` = old value; a following read returns the new value.
- With `AXIL_REGFILE_PROT_CHK_EN`:
  - Write with `AWPROT=3'b000` → SLVERR and no change.
  - Same write with `AWPROT=3'b001` → OKAY and register updated.

Source files
------------

// File: rtl/axil_regfile_if.sv
// axi_lite_if: AXI4-Lite bus bundle.
// It carries a 32-bit address, 32-bit data and a 4-bit write strobe.
// The master modport drives requests. The slave modport terminates them.
interface axi_lite_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axil_regfile.sv
// axil_regfile: AXI4-Lite slave register file.
//  - Holds NUM_REGS 32-bit read/write registers with byte-strobe writes.
//  - Exposes every register to fabric logic as a flat, registered vector (regs_o).
//  - AW and W are captured into independent one-entry slots. A write commits once
//    both slots are full and no B response is outstanding.
//  - Any access outside [BASE_ADDR, BASE_ADDR + 4*NUM_REGS) answers SLVERR and
//    leaves every register unchanged.
// Optional feature, macro AXIL_REGFILE_PROT_CHK_EN:
//  - An access with PROT[0]==0 (unprivileged) also answers SLVERR.
//  - Such a write changes no register. Such a read returns zero data.
module axil_regfile #(
  parameter int unsigned NUM_REGS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axi_lite_if.slave              s_axi,
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int unsigned IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [31:0] SPAN_BYTES  = 32'(4 * NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // ---------------------------------------------------------------------------
  // Address decode.
  // The subtraction is 33 bits wide so that an address below BASE_ADDR shows up
  // as a borrow rather than wrapping into range. ADDR[1:0] never reaches the index.
  // ---------------------------------------------------------------------------
  function automatic logic addr_hit(input logic [31:0] addr);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return !off[32] && (off[31:0] < SPAN_BYTES);
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // Ready gating that keeps all channels closed until one edge after reset release
  logic              rdy_en_reg;

  // AW / W holding slots
  logic              aw_full_reg;
  logic [31:0]       aw_addr_reg;
  logic              w_full_reg;
  logic [31:0]       w_data_reg;
  logic [3:0]        w_strb_reg;

  // B / R response state
  logic              b_valid_reg, b_valid_next;
  logic [1:0]        b_resp_reg,  b_resp_next;
  logic              r_valid_reg, r_valid_next;
  logic [31:0]       r_data_reg,  r_data_next;
  logic [1:0]        r_resp_reg,  r_resp_next;

  // Handshakes and decode results
  logic              aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic              commit;
  logic              wr_ok, rd_ok;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [31:0]       reg_arr [NUM_REGS];
  logic [31:0]       rd_val;

  // ---------------------------------------------------------------------------
  // Channel handshakes
  // ---------------------------------------------------------------------------
  assign s_axi.awready = rdy_en_reg && !aw_full_reg;
  assign s_axi.wready  = rdy_en_reg && !w_full_reg;
  assign s_axi.arready = rdy_en_reg && !r_valid_reg;
  assign s_axi.bvalid  = b_valid_reg;
  assign s_axi.bresp   = b_resp_reg;
  assign s_axi.rvalid  = r_valid_reg;
  assign s_axi.rdata   = r_data_reg;
  assign s_axi.rresp   = r_resp_reg;

  assign aw_hs  = s_axi.awvalid && s_axi.awready;
  assign w_hs   = s_axi.wvalid  && s_axi.wready;
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign b_hs   = b_valid_reg   && s_axi.bready;
  assign r_hs   = r_valid_reg   && s_axi.rready;

  // A pending B response blocks the next commit until the master takes it
  assign commit = aw_full_reg && w_full_reg && !b_valid_reg;

  assign wr_idx = addr_idx(aw_addr_reg);
  assign rd_idx = addr_idx(s_axi.araddr);

`ifdef AXIL_REGFILE_PROT_CHK_EN
  logic aw_priv_reg;

  // Keep the privilege bit of the captured write address for the commit decision
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_priv_reg <= 1'b0;
    end else if (aw_hs) begin
      aw_priv_reg <= s_axi.awprot[0];
    end
  end

  assign wr_ok = addr_hit(aw_addr_reg) && aw_priv_reg;
  assign rd_ok = addr_hit(s_axi.araddr) && s_axi.arprot[0];
`else
  assign wr_ok = addr_hit(aw_addr_reg);
  assign rd_ok = addr_hit(s_axi.araddr);
`endif

  // Only PROT[0] matters (and only with the check enabled); the other bits are dropped
  logic unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  // ---------------------------------------------------------------------------
  // Sequential control
  // ---------------------------------------------------------------------------

  // Open the ready signals on the first edge after reset release
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdy_en_reg <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
    end
  end

  // AW slot: fill on handshake, drain on commit (never both in one cycle)
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_full_reg <= 1'b0;
      aw_addr_reg <= '0;
    end else if (aw_hs) begin
      aw_full_reg <= 1'b1;
      aw_addr_reg <= s_axi.awaddr;
    end else if (commit) begin
      aw_full_reg <= 1'b0;
    end
  end

  // W slot: fill on handshake, drain on commit (never both in one cycle)
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_full_reg <= 1'b0;
      w_data_reg <= '0;
      w_strb_reg <= '0;
    end else if (w_hs) begin
      w_full_reg <= 1'b1;
      w_data_reg <= s_axi.wdata;
      w_strb_reg <= s_axi.wstrb;
    end else if (commit) begin
      w_full_reg <= 1'b0;
    end
  end

  // B next state: raise on commit, drop once the master accepts
  always_comb begin
    b_valid_next = b_valid_reg;
    b_resp_next  = b_resp_reg;
    if (commit) begin
      b_valid_next = 1'b1;
      b_resp_next  = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (b_hs) begin
      b_valid_next = 1'b0;
    end
  end

  // B response register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      b_valid_reg <= 1'b0;
      b_resp_reg  <= RESP_OKAY;
    end else begin
      b_valid_reg <= b_valid_next;
      b_resp_reg  <= b_resp_next;
    end
  end

  // Read mux, taken from the current register values.
  // On a commit edge this yields the pre-write data.
  assign rd_val = reg_arr[rd_idx];

  // R next state: load on AR handshake, hold until the master accepts
  always_comb begin
    r_valid_next = r_valid_reg;
    r_data_next  = r_data_reg;
    r_resp_next  = r_resp_reg;
    if (ar_hs) begin
      r_valid_next = 1'b1;
      r_data_next  = rd_ok ? rd_val : 32'h0;
      r_resp_next  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      r_valid_next = 1'b0;
    end
  end

  // R response register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_valid_reg <= 1'b0;
      r_data_reg  <= '0;
      r_resp_reg  <= RESP_OKAY;
    end else begin
      r_valid_reg <= r_valid_next;
      r_data_reg  <= r_data_next;
      r_resp_reg  <= r_resp_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Register storage.
  // These are flops rather than RAM, because every register is visible on regs_o.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [31:0] val_reg;
      logic        wr_sel;

      assign wr_sel = commit && wr_ok && (wr_idx == IDX_W'(gi));

      // Byte-strobed update of this register on a committing in-range write
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          val_reg <= RESET_VAL;
        end else if (wr_sel) begin
          for (int k = 0; k < 4; k++) begin
            if (w_strb_reg[k]) begin
              val_reg[8*k +: 8] <= w_data_reg[8*k +: 8];
            end
          end
        end
      end

      assign reg_arr[gi]          = val_reg;
      assign regs_o[32*gi +: 32]  = val_reg;
    end
  endgenerate

endmodule

// File: tb/tb_axil_regfile.sv
// tb_axil_regfile: directed scoreboard bench for axil_regfile.
// Stimulus pushes the expected B/R responses into queues.
// Separate monitors pop those queues and compare whenever a B or R handshake occurs.
`timescale 1ns/1ps
module tb_axil_regfile;

  localparam int unsigned NUM_REGS  = 8;
  localparam logic [31:0] BASE_ADDR = 32'h0000_1000;
  localparam logic [31:0] RESET_VAL = 32'h1234_5678;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;
  localparam int          TIMEOUT   = 50;

  logic                   ACLK    = 1'b0;
  logic                   ARESETn = 1'b0;
  logic [NUM_REGS*32-1:0] regs_o;

  axi_lite_if s_axi_bus ();

  axil_regfile #(
    .NUM_REGS  (NUM_REGS),
    .BASE_ADDR (BASE_ADDR),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .s_axi   (s_axi_bus),
    .regs_o  (regs_o)
  );

  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  logic [1:0]  b_exp_q [$];
  logic [33:0] r_exp_q [$];   // {rresp, rdata}
  logic [31:0] model [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < NUM_REGS; i++) begin
      check($sformatf("%s.reg%0d", name, i), 64'(regs_o[32*i +: 32]), 64'(model[i]));
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no handshake expected one within %0d cycles", name, TIMEOUT);
  endtask

  task automatic sync();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [2:0] prot);
    logic hs;
    s_axi_bus.awaddr  = addr;
    s_axi_bus.awprot  = prot;
    s_axi_bus.awvalid = 1'b1;
    for (int n = 0; n <= TIMEOUT; n++) begin
      @(negedge ACLK);
      hs = s_axi_bus.awready;
      @(posedge ACLK);
      #1;
      if (hs) break;
      if (n == TIMEOUT) timeout_fail("aw_handshake");
    end
    s_axi_bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
    logic hs;
    s_axi_bus.wdata  = data;
    s_axi_bus.wstrb  = strb;
    s_axi_bus.wvalid = 1'b1;
    for (int n = 0; n <= TIMEOUT; n++) begin
      @(negedge ACLK);
      hs = s_axi_bus.wready;
      @(posedge ACLK);
      #1;
      if (hs) break;
      if (n == TIMEOUT) timeout_fail("w_handshake");
    end
    s_axi_bus.wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] addr, input logic [2:0] prot);
    logic hs;
    s_axi_bus.araddr  = addr;
    s_axi_bus.arprot  = prot;
    s_axi_bus.arvalid = 1'b1;
    for (int n = 0; n <= TIMEOUT; n++) begin
      @(negedge ACLK);
      hs = s_axi_bus.arready;
      @(posedge ACLK);
      #1;
      if (hs) break;
      if (n == TIMEOUT) timeout_fail("ar_handshake");
    end
    s_axi_bus.arvalid = 1'b0;
  endtask

  // B monitor: one comparison per B handshake
  always @(negedge ACLK) begin : b_mon
    logic [1:0] e;
    if (ARESETn && s_axi_bus.bvalid && s_axi_bus.bready) begin
      if (b_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got bresp %b expected no response", s_axi_bus.bresp);
      end else begin
        e = b_exp_q.pop_front();
        check("bresp", 64'(s_axi_bus.bresp), 64'(e));
      end
    end
  end

  // R monitor: compares data and response per R handshake
  always @(negedge ACLK) begin : r_mon
    logic [33:0] e;
    if (ARESETn && s_axi_bus.rvalid && s_axi_bus.rready) begin
      if (r_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL r_unexpected: got rdata %h expected no response", s_axi_bus.rdata);
      end else begin
        e = r_exp_q.pop_front();
        check("rresp", 64'(s_axi_bus.rresp), 64'(e[33:32]));
        check("rdata", 64'(s_axi_bus.rdata), 64'(e[31:0]));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    s_axi_bus.awaddr  = '0;
    s_axi_bus.awprot  = '0;
    s_axi_bus.awvalid = 1'b0;
    s_axi_bus.wdata   = '0;
    s_axi_bus.wstrb   = '0;
    s_axi_bus.wvalid  = 1'b0;
    s_axi_bus.bready  = 1'b1;
    s_axi_bus.araddr  = '0;
    s_axi_bus.arprot  = '0;
    s_axi_bus.arvalid = 1'b0;
    s_axi_bus.rready  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;

    // ---- reset state and release ----
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_awready", 64'(s_axi_bus.awready), 64'(0));
    check("rst_wready",  64'(s_axi_bus.wready),  64'(0));
    check("rst_arready", 64'(s_axi_bus.arready), 64'(0));
    check("rst_bvalid",  64'(s_axi_bus.bvalid),  64'(0));
    check("rst_rvalid",  64'(s_axi_bus.rvalid),  64'(0));
    check("rst_rdata",   64'(s_axi_bus.rdata),   64'(0));
    check_regs("rst");
    sync();
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("rel_awready_before_edge", 64'(s_axi_bus.awready), 64'(0));
    @(negedge ACLK);
    check("rel_awready", 64'(s_axi_bus.awready), 64'(1));
    check("rel_wready",  64'(s_axi_bus.wready),  64'(1));
    check("rel_arready", 64'(s_axi_bus.arready), 64'(1));

    // ---- AW first, W three cycles later ----
    sync();
    b_exp_q.push_back(OKAY);
    send_aw(BASE_ADDR + 32'd8, 3'b001);
    repeat (3) @(posedge ACLK);
    #1;
    send_w(32'hDEAD_BEEF, 4'hF);
    @(negedge ACLK);
    check("wr1_bvalid_at_whs", 64'(s_axi_bus.bvalid), 64'(0));
    @(negedge ACLK);
    check("wr1_bvalid_next", 64'(s_axi_bus.bvalid), 64'(1));
    model[2] = 32'hDEAD_BEEF;
    check_regs("wr1");

    // ---- W first, then AW; single byte strobe ----
    sync();
    b_exp_q.push_back(OKAY);
    send_w(32'h0000_0011, 4'b0001);
    sync();
    send_aw(BASE_ADDR + 32'd8, 3'b001);
    repeat (2) @(negedge ACLK);
    check("wr2_reg2", 64'(regs_o[64 +: 32]), 64'(32'hDEAD_BE11));
    model[2] = 32'hDEAD_BE11;

    // ---- out of range write and reads ----
    sync();
    b_exp_q.push_back(SLVERR);
    fork
      send_aw(BASE_ADDR + 32'd32, 3'b001);
      send_w(32'hFFFF_FFFF, 4'hF);
    join
    repeat (2) @(negedge ACLK);
    check_regs("oor_wr");
    sync();
    r_exp_q.push_back({SLVERR, 32'h0});
    send_ar(BASE_ADDR + 32'd32, 3'b001);
    r_exp_q.push_back({SLVERR, 32'h0});
    send_ar(BASE_ADDR - 32'd4, 3'b001);
    r_exp_q.push_back({OKAY, 32'hDEAD_BE11});
    send_ar(BASE_ADDR + 32'd8 + 32'd3, 3'b001);
    r_exp_q.push_back({OKAY, RESET_VAL});
    send_ar(BASE_ADDR, 3'b001);

    // ---- last register, alternate strobes ----
    sync();
    b_exp_q.push_back(OKAY);
    fork
      send_aw(BASE_ADDR + 32'd28, 3'b001);
      send_w(32'hFFFF_FFFF, 4'b1010);
    join
    repeat (2) @(negedge ACLK);
    model[7] = 32'hFF34_FF78;
    check_regs("strb1010");

    // ---- B backpressure: second write waits for first B ----
    sync();
    s_axi_bus.bready = 1'b0;
    b_exp_q.push_back(OKAY);
    fork
      send_aw(BASE_ADDR + 32'd16, 3'b001);
      send_w(32'h4444_4444, 4'hF);
    join
    b_exp_q.push_back(OKAY);
    fork
      send_aw(BASE_ADDR + 32'd16, 3'b001);
      send_w(32'h5555_5555, 4'hF);
    join
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("bp_bvalid_held", 64'(s_axi_bus.bvalid), 64'(1));
      check("bp_reg4_first", 64'(regs_o[128 +: 32]), 64'(32'h4444_4444));
    end
    sync();
    s_axi_bus.bready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("bp_bvalid_after_hs", 64'(s_axi_bus.bvalid), 64'(0));
    check("bp_reg4_not_yet", 64'(regs_o[128 +: 32]), 64'(32'h4444_4444));
    @(negedge ACLK);
    check("bp_bvalid_second", 64'(s_axi_bus.bvalid), 64'(1));
    check("bp_reg4_second", 64'(regs_o[128 +: 32]), 64'(32'h5555_5555));
    model[4] = 32'h5555_5555;

    // ---- R backpressure ----
    sync();
    s_axi_bus.rready = 1'b0;
    r_exp_q.push_back({OKAY, 32'h5555_5555});
    send_ar(BASE_ADDR + 32'd16, 3'b001);
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      check("rbp_rvalid", 64'(s_axi_bus.rvalid), 64'(1));
      check("rbp_rdata", 64'(s_axi_bus.rdata), 64'(32'h5555_5555));
      check("rbp_arready", 64'(s_axi_bus.arready), 64'(0));
    end
    sync();
    s_axi_bus.rready = 1'b1;

    // ---- read on the commit edge of a write to the same register ----
    repeat (3) sync();
    b_exp_q.push_back(OKAY);
    r_exp_q.push_back({OKAY, RESET_VAL});
    fork
      send_aw(BASE_ADDR + 32'd12, 3'b001);
      send_w(32'hCAFE_F00D, 4'hF);
      begin
        @(posedge ACLK);
        #1;
        send_ar(BASE_ADDR + 32'd12, 3'b001);
      end
    join
    model[3] = 32'hCAFE_F00D;
    r_exp_q.push_back({OKAY, 32'hCAFE_F00D});
    send_ar(BASE_ADDR + 32'd12, 3'b001);
    @(negedge ACLK);
    check_regs("simul");

    // ---- PROT handling ----
    sync();
`ifdef AXIL_REGFILE_PROT_CHK_EN
    b_exp_q.push_back(SLVERR);
`else
    b_exp_q.push_back(OKAY);
    model[5] = 32'hAAAA_5555;
`endif
    fork
      send_aw(BASE_ADDR + 32'd20, 3'b000);
      send_w(32'hAAAA_5555, 4'hF);
    join
    repeat (2) @(negedge ACLK);
    check_regs("prot0_wr");
    sync();
`ifdef AXIL_REGFILE_PROT_CHK_EN
    r_exp_q.push_back({SLVERR, 32'h0});
`else
    r_exp_q.push_back({OKAY, 32'hDEAD_BE11});
`endif
    send_ar(BASE_ADDR + 32'd8, 3'b000);
    b_exp_q.push_back(OKAY);
    fork
      send_aw(BASE_ADDR + 32'd20, 3'b001);
      send_w(32'h5A5A_5A5A, 4'hF);
    join
    repeat (2) @(negedge ACLK);
    model[5] = 32'h5A5A_5A5A;
    check_regs("prot1_wr");

    // ---- reset mid-transaction discards captured AW and pending R ----
    repeat (2) sync();
    s_axi_bus.rready = 1'b0;
    send_ar(BASE_ADDR + 32'd4, 3'b001);
    send_aw(BASE_ADDR + 32'd4, 3'b001);
    ARESETn = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = RESET_VAL;
    @(negedge ACLK);
    check("mid_rst_rvalid", 64'(s_axi_bus.rvalid), 64'(0));
    check_regs("mid_rst");
    sync();
    s_axi_bus.rready = 1'b1;
    ARESETn = 1'b1;
    sync();
    send_w(32'h7777_7777, 4'hF);
    repeat (3) @(negedge ACLK);
    check("mid_rst_no_commit", 64'(s_axi_bus.bvalid), 64'(0));
    check("mid_rst_reg1", 64'(regs_o[32 +: 32]), 64'(RESET_VAL));
    sync();
    b_exp_q.push_back(OKAY);
    send_aw(BASE_ADDR + 32'd4, 3'b001);
    repeat (2) @(negedge ACLK);
    model[1] = 32'h7777_7777;
    check_regs("post_rst_wr");

    // ---- drain scoreboard ----
    for (int n = 0; n < 20; n++) begin
      if (b_exp_q.size() == 0 && r_exp_q.size() == 0) break;
      @(posedge ACLK);
    end
    @(negedge ACLK);
    check("b_queue_left", 64'(b_exp_q.size()), 64'(0));
    check("r_queue_left", 64'(r_exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
